s2mm_ring_cmd_gen: RTL
======================

// Module: s2mm_ring_cmd_gen
// PURPOSE
//  Parametrised S2MM command generator and status tracker for the AXI DataMover write path.
//  Splits a capture region into PKT_BYTES commands. Runs one-shot or as a continuous ring buffer,
//  with up to MAX_OUTST commands in flight. Checks each in-order status tag and reports
//  progress/errors to the register block. Sits entirely in the axis_st_clk (100MHz) domain.
// PARAMETERS
//  ADDR_W     32    AXI address width (32 or 64); command width CMD_W = ADDR_W+40
//  PKT_BYTES  4096  bytes per full command (power of 2, <= 2^23-1)
//  MAX_OUTST  4     max commands issued without a returned status (1..15)
//  TAG_W      4     command tag width (fixed 4, DataMover format)
// PORTS
//  axis_st_clk     in   1        clock
//  axis_st_rstb    in   1        reset, asynchronous, active-low
//  write_start     in   1        1-cycle pulse: latch config, begin capture
//  write_stop      in   1        1-cycle pulse: stop issuing, drain, go DONE
//  write_reset     in   1        sync soft reset (level), dominates all
//  ring_mode       in   1        0 one-shot, 1 wrap to base_addr forever
//  base_addr       in   ADDR_W   region start (PKT_BYTES aligned)
//  cap_size        in   32       region size in bytes
//  m_axis_cmd_tdata  out CMD_W   DataMover command
//  m_axis_cmd_tvalid out 1       command valid
//  m_axis_cmd_tready in  1       command accepted
//  s_axis_sts_tdata  in  8       DataMover status {OKAY,SLVERR,DECERR,INTERR,TAG[3:0]}
//  s_axis_sts_tvalid in  1       status valid
//  s_axis_sts_tready out 1       tied high except in reset
//  busy            out  1        state != IDLE/DONE/ERR
//  cap_done        out  1        sticky, capture finished cleanly
//  cap_err         out  1        sticky, bad status or tag mismatch
//  err_status      out  8        first offending status word
//  cur_addr        out  ADDR_W   address of last accepted command
//  wrap_count      out  16       ring passes completed (saturating)
//  sts_count       out  32       statuses received
// BEHAVIOUR
//  Reset (async or write_reset): all outputs 0, state IDLE, tag 0, outstanding 0.
//  write_reset clears outputs the same cycle it is sampled; tvalid drops without handshake.
//  The DataMover must be reset alongside.
//  Command fields: [22:0] BTT, [23] TYPE=1 INCR, [29:24] DSA=0, [30] EOF=1, [31] DRR=0,
//   [ADDR_W+31:32] SADDR, [ADDR_W+35:ADDR_W+32] TAG, top 4 bits 0.
//  FSM: IDLE -start&cap_size!=0-> ISSUE. start with cap_size==0 is ignored; start while busy is ignored.
//   ISSUE: present a command when outstanding<MAX_OUTST and not stopping.
//     On tready&tvalid: cur_addr<=SADDR, addr+=BTT, remaining-=BTT, tag++ (mod 16),
//     outstanding++.
//     BTT = min(PKT_BYTES, remaining); the final chunk may be short.
//     remaining hits 0: ring_mode=1 -> addr<=base, remaining<=cap_size,
//       wrap_count++ (saturate at 0xFFFF); ring_mode=0 -> DRAIN.
//   write_stop in ISSUE -> DRAIN. A presented command is held until accepted
//     (tvalid never drops without ready).
//   DRAIN: no new commands; outstanding==0 -> DONE (cap_done=1).
//   DONE/ERR: hold until write_reset, or write_start (clears sticky flags, restarts).
//  Config (base, size, ring_mode) is latched on start; later changes have no effect until the next start.
//  Status: accepted every valid cycle; sts_count++, outstanding--.
//   Expected tag is an in-order counter.
//   OKAY=0 or any of bits[6:4] set, or tag!=expected -> cap_err=1, err_status latched
//     (first error only), state ERR, no further commands (hold any presented one).
//  Same-cycle cmd accept and status receipt: outstanding unchanged.
//  Status while outstanding==0 is a tag mismatch error.
//  Latency: first command valid 1 cycle after write_start; one command per cycle sustained.
//  Address arithmetic is modulo 2^ADDR_W; BTT is computed at 32 bits then truncated to 23.
// TESTING
//  1 base=0x1000_0000,size=16384,one-shot,tready=1,OK sts -> 4 cmds BTT=4096 addr +0x1000, tags 0..3, cap_done.
//  2 size=10000 -> BTT 4096,4096,1808; cur_addr=0x1000_2000; cap_done after 3rd status.
//  3 ring, size=8192, stop after 5 cmds -> addrs 0,+1000,0,+1000,0; wrap_count=2; DONE after drain.
//  4 sts stalled, MAX_OUTST=4 -> exactly 4 cmds issued then tvalid=0 until a status returns.
//  5 2nd status=0x41 (SLVERR) -> cap_err=1, err_status=0x41, no further cmds; 3rd bad sts keeps 0x41.
//  6 write_reset mid-ISSUE with tready=0 -> next cycle tvalid=0, all counters 0, IDLE; restart works.

Source files
------------

// File: rtl/s2mm_ring_cmd_gen.sv
// rtl/s2mm_ring_cmd_gen.sv - DataMover S2MM command generator and in-order status tracker
module s2mm_ring_cmd_gen #(
  parameter int ADDR_W    = 32,
  parameter int PKT_BYTES = 4096,
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = 4
) (
  input  logic                axis_st_clk,
  input  logic                axis_st_rstb,
  input  logic                write_start,
  input  logic                write_stop,
  input  logic                write_reset,
  input  logic                ring_mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [31:0]         cap_size,
  output logic [ADDR_W+39:0]  m_axis_cmd_tdata,
  output logic                m_axis_cmd_tvalid,
  input  logic                m_axis_cmd_tready,
  input  logic [7:0]          s_axis_sts_tdata,
  input  logic                s_axis_sts_tvalid,
  output logic                s_axis_sts_tready,
  output logic                busy,
  output logic                cap_done,
  output logic                cap_err,
  output logic [7:0]          err_status,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic [15:0]         wrap_count,
  output logic [31:0]         sts_count
);
  localparam int CMD_W = ADDR_W + 40;
  localparam logic [31:0] PKT32 = 32'(PKT_BYTES);
  localparam logic [3:0]  OUTST_LIM = 4'(MAX_OUTST);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d, cur_addr_q, cur_addr_d;
  logic [31:0]         size_q, size_d, rem_q, rem_d, sts_cnt_q, sts_cnt_d;
  logic                ring_q, ring_d, cvalid_q, cvalid_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d, sts_rdy_q, sts_rdy_d;
  logic [TAG_W-1:0]    tag_q, tag_d, exp_tag_q, exp_tag_d;
  logic [3:0]          outst_q, outst_d;
  logic [CMD_W-1:0]    cdata_q, cdata_d;
  logic [15:0]         wrap_q, wrap_d;
  logic [7:0]          err_sts_q, err_sts_d;

  logic        accept, sts_in, sts_bad, idle_like;
  logic [31:0] btt_cur, btt_nx, rem_after;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    ring_d     = ring_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tag_d      = tag_q;
    exp_tag_d  = exp_tag_q;
    cur_addr_d = cur_addr_q;
    wrap_d     = wrap_q;
    sts_cnt_d  = sts_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    err_sts_d  = err_sts_q;
    sts_rdy_d  = 1'b1;
    cvalid_d   = cvalid_q;
    cdata_d    = cdata_q;

    accept    = cvalid_q & m_axis_cmd_tready;
    sts_in    = s_axis_sts_tvalid & sts_rdy_q;
    btt_cur   = (rem_q < PKT32) ? rem_q : PKT32;
    rem_after = rem_q - btt_cur;
    sts_bad   = ~s_axis_sts_tdata[7] | (|s_axis_sts_tdata[6:4]) |
                (s_axis_sts_tdata[TAG_W-1:0] != exp_tag_q) | (outst_q == 4'd0);
    outst_d   = outst_q + 4'(accept) - 4'(sts_in && (outst_q != 4'd0));
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

    if (accept) begin
      cur_addr_d = addr_q;
      addr_d     = addr_q + ADDR_W'(btt_cur);
      rem_d      = rem_after;
      tag_d      = tag_q + 1'b1;
      if (rem_after == 32'd0) begin
        if (ring_q) begin
          addr_d = base_q;
          rem_d  = size_q;
          if (wrap_q != 16'hFFFF) wrap_d = wrap_q + 16'd1;
        end else if (state_q == S_ISSUE) begin
          state_d = S_DRAIN;
        end
      end
    end

    if (state_q == S_ISSUE && write_stop) state_d = S_DRAIN;
    if (state_q == S_DRAIN && outst_q == 4'd0 && !cvalid_q) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end

    // Only the first bad status is kept; later ones in ERR just count
    if (sts_in) begin
      sts_cnt_d = sts_cnt_q + 32'd1;
      exp_tag_d = exp_tag_q + 1'b1;
      if ((state_q == S_ISSUE || state_q == S_DRAIN) && sts_bad) begin
        state_d   = S_ERR;
        err_d     = 1'b1;
        err_sts_d = s_axis_sts_tdata;
      end
    end

    // A command still held from before an error must complete before a restart
    if (write_start && cap_size != 32'd0 && idle_like && !cvalid_q) begin
      state_d   = S_ISSUE;
      base_d    = base_addr;
      size_d    = cap_size;
      ring_d    = ring_mode;
      addr_d    = base_addr;
      rem_d     = cap_size;
      tag_d     = '0;
      exp_tag_d = '0;
      outst_d   = 4'd0;
      wrap_d    = 16'd0;
      sts_cnt_d = 32'd0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_sts_d = 8'd0;
    end

    btt_nx = (rem_d < PKT32) ? rem_d : PKT32;
    if (!(cvalid_q && !accept)) begin
      cvalid_d = (state_d == S_ISSUE) && (outst_d < OUTST_LIM);
      cdata_d  = {4'd0, tag_d, addr_d, 1'b0, 1'b1, 6'd0, 1'b1, 23'(btt_nx)};
    end
    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
    if (!axis_st_rstb || write_reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      size_q     <= '0;
      ring_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      tag_q      <= '0;
      exp_tag_q  <= '0;
      outst_q    <= '0;
      cur_addr_q <= '0;
      wrap_q     <= '0;
      sts_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_sts_q  <= '0;
      sts_rdy_q  <= 1'b0;
      cvalid_q   <= 1'b0;
      cdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      ring_q     <= ring_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tag_q      <= tag_d;
      exp_tag_q  <= exp_tag_d;
      outst_q    <= outst_d;
      cur_addr_q <= cur_addr_d;
      wrap_q     <= wrap_d;
      sts_cnt_q  <= sts_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_sts_q  <= err_sts_d;
      sts_rdy_q  <= sts_rdy_d;
      cvalid_q   <= cvalid_d;
      cdata_q    <= cdata_d;
      busy_q     <= busy_d;
    end
  end

  assign m_axis_cmd_tdata  = cdata_q;
  assign m_axis_cmd_tvalid = cvalid_q;
  assign s_axis_sts_tready = sts_rdy_q;
  assign busy              = busy_q;
  assign cap_done          = done_q;
  assign cap_err           = err_q;
  assign err_status        = err_sts_q;
  assign cur_addr          = cur_addr_q;
  assign wrap_count        = wrap_q;
  assign sts_count         = sts_cnt_q;
endmodule
